// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: datapath address/data -> aligned word bus access with byte enables and load extension.
// Latency: 1 (IDLE) + N (REQ, ready on Nth) + 1 (DONE); misaligned 2; timeout TIMEOUT+2.
// Backpressure: holds stall while the bus withholds mem_ready; aborts with bus_err after TIMEOUT REQ cycles.
module lsu_mem_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, uns_q;
    logic [1:0]  size_q, off_q;
    logic [3:0]  be_q;

    logic        aligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [15:0] shifted;
    logic [31:0] load_ext;
    logic        accept, bad, timeout_hit;

    always_comb begin
        aligned = 1'b0;
        be_c    = 4'b0000;
        wdata_c = req_wdata;
        case (req_size)
            2'b00: begin
                aligned = 1'b1;
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                aligned = (req_addr[1:0] == 2'b00);
                be_c    = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
    end

    assign accept      = (state == IDLE) && req_valid && aligned;
    assign bad         = (state == IDLE) && req_valid && !aligned;
    // Ready on the final allowed cycle takes priority over the abort.
    assign timeout_hit = (state == REQ) && !mem_ready && (cnt == 8'(TIMEOUT - 1));

    assign shifted = 16'(mem_rdata >> {off_q, 3'b000});

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)   state_nxt = REQ;
                else if (bad) state_nxt = DONE;
            end
            REQ: begin
                if (mem_ready || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= {req_addr[31:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                off_q   <= req_addr[1:0];
                cnt     <= 8'd0;
            end else if (bad) begin
                rdata_q <= 32'd0;
            end else if (state == REQ) begin
                if (mem_ready) begin
                    if (!we_q) rdata_q <= load_ext;
                end else if (timeout_hit) begin
                    rdata_q <= 32'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign stall     = req_valid && (state != DONE);
    assign misalign  = bad;
    assign bus_err   = timeout_hit;
    assign rdata     = rdata_q;
    assign mem_valid = (state == REQ);
    assign mem_we    = mem_valid && we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Randomized scoreboard bench for lsu_mem_bridge with a byte-lane reference model.
module tb_lsu_mem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_mem_bridge #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic [31:0] rdata; int lat; bit mis; bit berr; } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 0;
    int          cur_waits = 0;
    logic [31:0] cur_mrdata = 32'd0;
    logic [31:0] model_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: access width in bytes, lanes by byte offset, extension by arithmetic.
    function automatic logic [31:0] ref_load(input int sz, input bit uns, input int off, input logic [31:0] d);
        longint unsigned v;
        int n;
        if (sz == 2) return d;
        n = (sz == 0) ? 1 : 2;
        v = (longint'(d) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!uns && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] w);
        logic [31:0] v;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = w[8*(i % n) +: 8];
        return v;
    endfunction

    // Memory responder: ready after cur_waits wait cycles; garbage on mem_rdata otherwise.
    int req_cyc = 0;
    always @(posedge clk) begin
        #1;
        if (mem_valid) begin
            mem_ready = (req_cyc == cur_waits);
            mem_rdata = mem_ready ? cur_mrdata : $urandom;
            req_cyc++;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            req_cyc = 0;
        end
    end

    // Monitor: checks bus beats and instruction completion against the scoreboard queues.
    int  cyc = 0;
    bit  seen_mis = 0, seen_berr = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!req_valid) chk("stall_idle", stall, 0);
            if (misalign && bus_err) chk("pulse_overlap", 1, 0);
            if (mem_valid) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus", 1, 0);
                end else begin
                    chk("mem_addr", mem_addr, bus_q[0].addr);
                    chk("mem_be", mem_be, bus_q[0].be);
                    chk("mem_we", mem_we, bus_q[0].we);
                    if (bus_q[0].we) chk("mem_wdata", mem_wdata, bus_q[0].wdata);
                    if (mem_ready || bus_err) void'(bus_q.pop_front());
                end
            end
            if (req_valid) begin
                cyc++;
                if (misalign) seen_mis = 1;
                if (bus_err) seen_berr = 1;
                if (!stall) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        done_exp_t d;
                        d = done_q.pop_front();
                        chk("rdata", rdata, d.rdata);
                        chk("latency", cyc, d.lat);
                        chk("misalign_seen", seen_mis, d.mis);
                        chk("bus_err_seen", seen_berr, d.berr);
                    end
                    cyc = 0; seen_mis = 0; seen_berr = 0;
                end
            end
        end
    end

    task automatic do_txn(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mrd, input int waits);
        bit mis;
        int k;
        mis = (sz == 3) || ((addr % (1 << sz)) != 0);
        if (mis) begin
            model_rdata = 32'd0;
            done_q.push_back('{32'd0, 2, 1'b1, 1'b0});
        end else begin
            bus_exp_t b;
            b.addr  = addr & 32'hFFFF_FFFC;
            b.be    = 4'(((1 << (1 << sz)) - 1) << (addr % 4));
            b.we    = we;
            b.wdata = ref_wdata(sz, wd);
            bus_q.push_back(b);
            if (waits >= TMO) begin
                model_rdata = 32'd0;
                done_q.push_back('{32'd0, TMO + 2, 1'b0, 1'b1});
            end else begin
                if (!we) model_rdata = ref_load(sz, uns, int'(addr % 4), mrd);
                done_q.push_back('{model_rdata, waits + 3, 1'b0, 1'b0});
            end
        end
        cur_waits = waits; cur_mrdata = mrd;
        req_we = we; req_size = 2'(sz); req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (stall && k < 400);
        if (stall) chk("done_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_misalign"}, misalign, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("in_reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_all_zero("idle");
        end
        @(posedge clk); #1;
        mon_en = 1;

        do_txn(1, 2, 0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 2);
        do_txn(0, 0, 0, 32'h0000_0013, 32'h0, 32'h80AA_BBCC, 0);
        do_txn(0, 0, 1, 32'h0000_0013, 32'h0, 32'h80AA_BBCC, 0);
        do_txn(0, 1, 1, 32'h0000_0022, 32'h0, 32'hF00D_1234, 1);
        do_txn(1, 1, 0, 32'h0000_0022, 32'h0000_ABCD, 32'h0, 0);
        do_txn(0, 2, 0, 32'h0000_0102, 32'h0, 32'h1234_5678, 0);
        do_txn(0, 3, 0, 32'h0000_0100, 32'h0, 32'h1234_5678, 0);
        do_txn(0, 2, 0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1);
        do_txn(0, 2, 0, 32'h0000_0204, 32'h0, 32'h1111_2222, 255);
        do_txn(0, 1, 0, 32'h0000_0206, 32'h0, 32'h8765_4321, TMO - 1);
        do_txn(1, 0, 0, 32'h0000_0301, 32'h0000_005A, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            int r, sz, w;
            logic [31:0] a;
            r  = $urandom_range(0, 15);
            sz = (r < 15) ? r % 3 : 3;
            a  = $urandom;
            if (sz < 3 && $urandom_range(0, 1) == 1) a = a & ~32'((1 << sz) - 1);
            w  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, TMO - 1);
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, w);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (2) @(negedge clk);
        chk("queues_drained", bus_q.size() + done_q.size(), 0);

        // Async reset in the second REQ cycle abandons the access.
        mon_en = 0;
        @(posedge clk); #1;
        cur_waits = 255;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0400;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_valid", mem_valid, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mem_valid_drop", mem_valid, 0);
        chk("rst_bus_err", bus_err, 0);
        req_valid = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        model_rdata = 32'd0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", mem_valid, 0);
            chk("post_rst_bus_err", bus_err, 0);
            chk("post_rst_stall", stall, 0);
        end
        @(posedge clk); #1;
        mon_en = 1;
        do_txn(0, 1, 0, 32'h0000_0402, 32'h0, 32'h9ABC_0000, 0);
        repeat (2) @(negedge clk);
        chk("queues_drained_end", bus_q.size() + done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
